// File: rtl/elevator_car_controller.sv
// Single-car collective (SCAN) controller for 8 floors: consumes latched hall/car
// requests and reports floor, status code and travel direction, all registered.
module elevator_car_controller #(
  parameter int unsigned MOVE_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] upcall,
  input  logic [7:0] downcall,
  input  logic [7:0] floor_btn,
  output logic [2:0] floor,
  output logic [3:0] status,
  output logic       dir_up,
  output logic       door_open
);

  localparam int unsigned MAX_CYC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LAST = TW'(DOOR_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    MOVE_UP    = 4'd1,
    MOVE_DOWN  = 4'd2,
    CHECK      = 4'd3,
    DOOR_OPEN  = 4'd7,
    DOOR_CLOSE = 4'd8
  } state_t;

  state_t        state, state_next, d_state;
  logic [TW-1:0] timer, timer_next;
  logic [2:0]    floor_next;
  logic          dir_next, d_dir;

  logic [7:0] req, above_mask, below_mask;
  logic       here, above, below, stop_up, stop_dn;

  always_comb begin
    req        = upcall | downcall | floor_btn;
    above_mask = 8'(8'hFE << floor);
    below_mask = ~(8'(8'hFF << floor));
    here       = req[floor];
    above      = |(req & above_mask);
    below      = |(req & below_mask);
    stop_up    = floor_btn[floor] | upcall[floor];
    stop_dn    = floor_btn[floor] | downcall[floor];
  end

  // Collective decision: keep serving the current sweep direction, reverse only when it is exhausted.
  always_comb begin
    d_state = IDLE;
    d_dir   = dir_up;
    if (dir_up) begin
      if (stop_up)     d_state = DOOR_OPEN;
      else if (above)  d_state = MOVE_UP;
      else if (here)   d_state = DOOR_OPEN;
      else if (below) begin
        d_state = MOVE_DOWN;
        d_dir   = 1'b0;
      end
    end else begin
      if (stop_dn)     d_state = DOOR_OPEN;
      else if (below)  d_state = MOVE_DOWN;
      else if (here)   d_state = DOOR_OPEN;
      else if (above) begin
        d_state = MOVE_UP;
        d_dir   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      floor     <= '0;
      dir_up    <= 1'b1;
      timer     <= '0;
      door_open <= 1'b0;
    end else begin
      state     <= state_next;
      floor     <= floor_next;
      dir_up    <= dir_next;
      timer     <= timer_next;
      door_open <= (state_next == DOOR_OPEN);
    end
  end

  always_comb begin
    state_next = state;
    floor_next = floor;
    dir_next   = dir_up;
    timer_next = timer;
    case (state)
      IDLE, CHECK: begin
        state_next = d_state;
        dir_next   = d_dir;
        timer_next = '0;
      end
      MOVE_UP: begin
        if (timer == MOVE_LAST) begin
          if (floor != 3'd7) floor_next = floor + 3'd1;
          state_next = CHECK;
          timer_next = '0;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      MOVE_DOWN: begin
        if (timer == MOVE_LAST) begin
          if (floor != 3'd0) floor_next = floor - 3'd1;
          state_next = CHECK;
          timer_next = '0;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      DOOR_OPEN: begin
        if (timer == DOOR_LAST) begin
          state_next = DOOR_CLOSE;
          timer_next = '0;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      DOOR_CLOSE: begin
        // A new request at this floor reopens the door even on the final close cycle.
        if (here) begin
          state_next = DOOR_OPEN;
          timer_next = '0;
        end else if (timer == DOOR_LAST) begin
          state_next = CHECK;
          timer_next = '0;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  always_comb begin
    status = state;
  end

endmodule

// File: tb/tb_elevator_car_controller.sv
// Scoreboard bench for elevator_car_controller: expected state-change events are queued
// by the stimulus and checked (value and dwell time) by a negedge monitor.
module tb_elevator_car_controller;

  localparam int unsigned MC = 4;
  localparam int unsigned DC = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] upcall = '0;
  logic [7:0] downcall = '0;
  logic [7:0] floor_btn = '0;
  logic [2:0] floor;
  logic [3:0] status;
  logic       dir_up;
  logic       door_open;

  elevator_car_controller #(.MOVE_CYCLES(MC), .DOOR_CYCLES(DC)) dut (
    .clk       (clk),
    .rst       (rst),
    .upcall    (upcall),
    .downcall  (downcall),
    .floor_btn (floor_btn),
    .floor     (floor),
    .status    (status),
    .dir_up    (dir_up),
    .door_open (door_open)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [2:0]  fl;
    logic        d;
    int unsigned len;   // expected dwell in cycles, 0 = not checked
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push(input logic [3:0] st, input int fl, input logic d, input int unsigned len);
    exp_t e;
    e.st  = st;
    e.fl  = 3'(fl);
    e.d   = d;
    e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic exp_moves(input int from, input int to, input logic d);
    int f;
    f = from;
    while (f != to) begin
      if (to > f) begin
        push(4'd1, f, d, MC);
        f++;
      end else begin
        push(4'd2, f, d, MC);
        f--;
      end
      push(4'd3, f, d, 1);
    end
  endtask

  task automatic exp_door(input int f, input logic d);
    push(4'd7, f, d, DC);
    push(4'd8, f, d, DC);
    push(4'd3, f, d, 1);
  endtask

  task automatic exp_idle(input int f, input logic d);
    push(4'd0, f, d, 0);
  endtask

  // Request-buffer model: requests at the serviced floor drop while the door is open.
  task automatic step();
    @(posedge clk);
    #1;
    if (door_open === 1'b1) begin
      upcall[floor]    = 1'b0;
      downcall[floor]  = 1'b0;
      floor_btn[floor] = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d expected events pending after %0d cycles, required 0",
               name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic wait_state(input logic [3:0] st, input logic [2:0] fl, input int budget,
                            input string name);
    int n;
    n = 0;
    while (!(status == st && floor == fl) && n < budget) begin
      step();
      n++;
    end
    tests++;
    if (!(status == st && floor == fl)) begin
      fails++;
      $display("FAIL %s: status=%0d floor=%0d, required status=%0d floor=%0d",
               name, status, floor, st, fl);
    end
  endtask

  // Monitor: every change of the observable tuple is one event to match.
  logic [8:0]  prev;
  logic [8:0]  cur;
  bit          have_prev = 1'b0;
  int unsigned run_len = 0;
  int unsigned len_exp = 0;
  exp_t        e;

  always @(negedge clk) begin
    cur = {status, floor, dir_up, door_open};
    if (!have_prev || cur !== prev) begin
      if (have_prev && len_exp != 0) begin
        tests++;
        if (run_len != len_exp) begin
          fails++;
          $display("FAIL dwell status=%0d floor=%0d: held %0d cycles, required %0d",
                   prev[8:5], prev[4:2], run_len, len_exp);
        end
      end
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected event: status=%0d floor=%0d dir_up=%0b door_open=%0b, none required",
                 status, floor, dir_up, door_open);
        len_exp = 0;
      end else begin
        e = exp_q.pop_front();
        if (status !== e.st || floor !== e.fl || dir_up !== e.d || door_open !== (e.st == 4'd7)) begin
          fails++;
          $display("FAIL event: got status=%0d floor=%0d dir_up=%0b door_open=%0b, required status=%0d floor=%0d dir_up=%0b door_open=%0b",
                   status, floor, dir_up, door_open, e.st, e.fl, e.d, (e.st == 4'd7));
        end
        len_exp = e.len;
      end
      run_len = 1;
    end else begin
      run_len++;
    end
    prev      = cur;
    have_prev = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and a simple up trip to floor 3
    exp_idle(0, 1'b1);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();
    floor_btn[3] = 1'b1;
    exp_moves(0, 3, 1'b1);
    exp_door(3, 1'b1);
    exp_idle(3, 1'b1);
    wait_drain(300, "up_trip");

    // Collective preference: upcall above is served before the downcall below
    downcall[2] = 1'b1;
    upcall[5]   = 1'b1;
    exp_moves(3, 5, 1'b1);
    exp_door(5, 1'b1);
    exp_moves(5, 2, 1'b0);
    exp_door(2, 1'b0);
    exp_idle(2, 1'b0);
    wait_drain(300, "collective");

    // Reopen on second DOOR_CLOSE cycle
    floor_btn[2] = 1'b1;
    push(4'd7, 2, 1'b0, DC);
    push(4'd8, 2, 1'b0, 2);
    exp_door(2, 1'b0);
    exp_idle(2, 1'b0);
    wait_state(4'd8, 3'd2, 50, "reach_close");
    step();
    upcall[2] = 1'b1;
    wait_drain(100, "reopen");

    // Async reset in the middle of a move at floor 5
    floor_btn[7] = 1'b1;
    exp_moves(2, 5, 1'b1);
    push(4'd1, 5, 1'b1, 0);
    exp_idle(0, 1'b1);
    wait_state(4'd1, 3'd5, 100, "reach_move5");
    step();
    #2;
    rst       = 1'b1;
    upcall    = '0;
    downcall  = '0;
    floor_btn = '0;
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (10) step();
    wait_drain(5, "reset_idle");

    // Pass-through: downcall at 4 skipped on the way up, served on the way down
    downcall[4]  = 1'b1;
    floor_btn[6] = 1'b1;
    exp_moves(0, 6, 1'b1);
    exp_door(6, 1'b1);
    exp_moves(6, 4, 1'b0);
    exp_door(4, 1'b0);
    exp_idle(4, 1'b0);
    wait_drain(300, "pass_through");

    // Top floor: go to 7, then a lone downcall at 7 opens without moving
    floor_btn[7] = 1'b1;
    exp_moves(4, 7, 1'b1);
    exp_door(7, 1'b1);
    exp_idle(7, 1'b1);
    wait_drain(300, "to_top");
    downcall[7] = 1'b1;
    exp_door(7, 1'b1);
    exp_idle(7, 1'b1);
    wait_drain(100, "top_boundary");

    // Bottom floor mirror
    floor_btn[0] = 1'b1;
    exp_moves(7, 0, 1'b0);
    exp_door(0, 1'b0);
    exp_idle(0, 1'b0);
    wait_drain(300, "to_bottom");
    upcall[0] = 1'b1;
    exp_door(0, 1'b0);
    exp_idle(0, 1'b0);
    wait_drain(100, "bottom_boundary");

    repeat (5) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/elevator_car_controller.md
Name: elevator_car_controller

Overview:
- Consumer end of the latched request interface. Reads the latched upcall, downcall and floor_btn vectors, runs a single 8-floor car with collective (SCAN) scheduling, and drives floor and status back to the request buffer.
- status==7 (DOOR_OPEN) is the service indication; the buffer clears requests for the current floor while it is asserted.
- Sits between the request buffer and the display/motor logic.

Parameters:
- MOVE_CYCLES, 8, clock cycles spent in a MOVE state per floor traversed (>=1)
- DOOR_CYCLES, 6, clock cycles spent in each of DOOR_OPEN and DOOR_CLOSE (>=1)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- upcall  input  8  latched up-call requests, bit i = floor i
- downcall  input  8  latched down-call requests
- floor_btn  input  8  latched in-car floor requests
- floor  output  3  current floor, 0..7
- status  output  4  state code (see Behaviour)
- dir_up  output  1  current/last travel direction, 1=up
- door_open  output  1  high exactly when status==7

Behaviour:
- Reset (async, any time, including mid-move or mid-door): floor=0, status=IDLE(0), dir_up=1, internal timer=0, door_open=0. The car does not resume the interrupted operation.
- Status codes: IDLE=0, MOVE_UP=1, MOVE_DOWN=2, CHECK=3, DOOR_OPEN=7, DOOR_CLOSE=8. No other codes are ever output.
- Definitions at current floor f:
  - req = upcall|downcall|floor_btn
  - here = req[f]
  - above = |req[7:f+1] (0 when f=7)
  - below = |req[f-1:0] (0 when f=0)
  - stop_up = floor_btn[f]|upcall[f]
  - stop_dn = floor_btn[f]|downcall[f]
- Decision function D, used in IDLE and CHECK:
  - dir_up=1: stop_up -> DOOR_OPEN; else above -> MOVE_UP; else here -> DOOR_OPEN; else below -> MOVE_DOWN with dir_up<=0; else IDLE.
  - dir_up=0: mirror of the above (stop_dn, below, here, above with dir_up<=1, IDLE).
- IDLE: applies D every cycle; stays in IDLE while req==0.
- MOVE_UP / MOVE_DOWN:
  - Timer counts 0..MOVE_CYCLES-1.
  - On the edge where the timer equals MOVE_CYCLES-1: floor +/-1, status<=CHECK, timer<=0.
  - Floor never wraps. MOVE_UP is never entered at f=7; MOVE_DOWN is never entered at f=0.
  - Requests that vanish mid-move do not abort the move; the move completes to the next floor.
- CHECK: exactly 1 cycle; applies D at the new floor.
- DOOR_OPEN:
  - Held DOOR_CYCLES cycles, then DOOR_CLOSE with timer<=0.
  - Requests at f arriving during DOOR_OPEN are absorbed; the timer is not extended.
- DOOR_CLOSE:
  - Held DOOR_CYCLES cycles, then CHECK.
  - If here==1 in any DOOR_CLOSE cycle: next state DOOR_OPEN, timer<=0 (reopen). Reopen takes priority over timer expiry.
- Entering DOOR_OPEN never changes dir_up.
- door_open is registered together with status, never glitched combinationally.
- Timer width is clog2(max(MOVE_CYCLES, DOOR_CYCLES)) bits; it is reset to 0 on every state change.
- All outputs are registered; input-to-status latency is 1 clk.

Test Plan:
- Use MOVE_CYCLES=4, DOOR_CYCLES=3 throughout.
- Idle then up trip:
  - Stimulus: reset, then floor_btn=8'h08 held until status==7.
  - Response: status 0->1 next edge; floor steps 1,2,3, each after 4 MOVE cycles + 1 CHECK cycle; status=7 for 3 cycles at floor 3; then status=8 for 3 cycles; then CHECK; then IDLE with floor=3, dir_up=1.
- Collective direction preference:
  - Stimulus: car at floor 3 with dir_up=1; downcall[2]=1 and upcall[5]=1.
  - Response: goes up first, stopping at 5; then dir_up=0, down to 2, door opens at 2.
- Pass-through:
  - Stimulus: car moving up from 1 with downcall[4]=1 and floor_btn[6]=1.
  - Response: no stop at 4 (CHECK at floor 4 goes straight to MOVE_UP); door opens at 6; then reverses and opens at 4.
- Reopen during close:
  - Stimulus: at floor 2 in DOOR_CLOSE cycle 2, set upcall[2]=1.
  - Response: next status=7 with the full 3-cycle DOOR_OPEN restarted; no CHECK in between.
- Async reset mid-move:
  - Stimulus: assert rst between edges while status=1 at floor 5.
  - Response: immediately floor=0, status=0, dir_up=1, door_open=0; after release, stays IDLE while req==0.
- Boundary floors:
  - Stimulus: car at 7 with only downcall[7]=1.
  - Response: DOOR_OPEN at 7 with no move; status never 1 at floor 7; mirror check at floor 0 for status 2.
